// File: rtl/pwm_comparador_if.sv
// Bus bundle between the current decoder and the PWM comparator stage:
// run request, duty reference and the registered PWM outputs.
`timescale 1ns/1ps
interface pwm_comparador_if;
  logic       enable;
  logic [9:0] Referencia;
  logic       pwm_out;
  logic       period_start;
  logic [9:0] duty_active;

  modport master (
    output enable,
    output Referencia,
    input  pwm_out,
    input  period_start,
    input  duty_active
  );

  modport slave (
    input  enable,
    input  Referencia,
    output pwm_out,
    output period_start,
    output duty_active
  );
endinterface

// File: rtl/pwm_comparador.sv
// Prescaled 1023-tick PWM with a shadow duty register reloaded only at period
// boundaries. Optional soft start (duty ramp per period) via `PWM_SOFT_START_EN.
`timescale 1ns/1ps
module pwm_comparador #(
  parameter int DIV       = 1,
  parameter int RAMP_STEP = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pwm_comparador_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(DIV - 1);
  localparam logic [9:0]  CNT_LAST = 10'd1022;
  localparam logic [10:0] STEP     = 11'(RAMP_STEP);

  // Move current toward target by at most STEP, never past the target.
  function automatic logic [9:0] ramp_toward(input logic [9:0] target,
                                             input logic [9:0] current);
    logic [10:0] t;
    logic [10:0] c;
    logic [9:0]  res;
    t = {1'b0, target};
    c = {1'b0, current};
    if (t > c) begin
      if ((t - c) <= STEP) res = target;
      else                 res = 10'(c + STEP);
    end else begin
      if ((c - t) <= STEP) res = target;
      else                 res = 10'(c - STEP);
    end
    return res;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] pre_cnt_r, pre_cnt_nxt_s;
  logic [9:0]  cnt_r, cnt_nxt_s;
  logic [9:0]  duty_r, duty_nxt_s;
  logic        pwm_r, pwm_nxt_s;
  logic        ps_r, ps_nxt_s;
  logic [9:0]  load_s;
  logic        tick_s;

  // Value written into the shadow duty register at a load edge
  always_comb begin
`ifdef PWM_SOFT_START_EN
    load_s = ramp_toward(bus.Referencia, duty_r);
`else
    load_s = bus.Referencia;
`endif
  end

  assign tick_s = (pre_cnt_r == PRE_LAST);

  // Next-state and next-register values for the IDLE/RUN controller
  always_comb begin
    state_nxt_s   = state_r;
    pre_cnt_nxt_s = pre_cnt_r;
    cnt_nxt_s     = cnt_r;
    duty_nxt_s    = duty_r;
    pwm_nxt_s     = 1'b0;
    ps_nxt_s      = 1'b0;
    case (state_r)
      IDLE: begin
        pre_cnt_nxt_s = 16'd0;
        cnt_nxt_s     = 10'd0;
        if (bus.enable) begin
          state_nxt_s = RUN;
          duty_nxt_s  = load_s;
          ps_nxt_s    = 1'b1;
        end else begin
          duty_nxt_s  = 10'd0;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          // Stop wins over a coincident wrap: no load, no period_start
          state_nxt_s   = IDLE;
          pre_cnt_nxt_s = 16'd0;
          cnt_nxt_s     = 10'd0;
          duty_nxt_s    = 10'd0;
        end else begin
          pwm_nxt_s = (cnt_r < duty_r);
          if (tick_s) begin
            pre_cnt_nxt_s = 16'd0;
            if (cnt_r == CNT_LAST) begin
              cnt_nxt_s  = 10'd0;
              duty_nxt_s = load_s;
              ps_nxt_s   = 1'b1;
            end else begin
              cnt_nxt_s  = cnt_r + 10'd1;
            end
          end else begin
            pre_cnt_nxt_s = pre_cnt_r + 16'd1;
          end
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pre_cnt_nxt_s = 16'd0;
        cnt_nxt_s     = 10'd0;
        duty_nxt_s    = 10'd0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      pre_cnt_r <= 16'd0;
      cnt_r     <= 10'd0;
      duty_r    <= 10'd0;
      pwm_r     <= 1'b0;
      ps_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pre_cnt_r <= pre_cnt_nxt_s;
      cnt_r     <= cnt_nxt_s;
      duty_r    <= duty_nxt_s;
      pwm_r     <= pwm_nxt_s;
      ps_r      <= ps_nxt_s;
    end
  end

  assign bus.pwm_out      = pwm_r;
  assign bus.period_start = ps_r;
  assign bus.duty_active  = duty_r;

endmodule

// File: tb/tb_pwm_comparador.sv
// Self-checking bench: DIV=1 and DIV=4 instances share stimulus and are checked
// every clock against a position-in-period model, plus directed duty counts.
`timescale 1ns/1ps
module tb_pwm_comparador;

  localparam int RAMP = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [9:0] ref_v = 10'd0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pwm_comparador_if if1 ();
  pwm_comparador_if if4 ();

  assign if1.enable     = en;
  assign if1.Referencia = ref_v;
  assign if4.enable     = en;
  assign if4.Referencia = ref_v;

  pwm_comparador #(.DIV(1), .RAMP_STEP(RAMP)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  pwm_comparador #(.DIV(4), .RAMP_STEP(RAMP)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));

  // Model: running flag, clock position within the period, applied duty, pwm.
  typedef struct packed {
    logic        run;
    logic [31:0] pos;
    logic [9:0]  duty;
    logic        pwm;
  } mstate_t;

  mstate_t m1 = '0;
  mstate_t m4 = '0;

  function automatic logic [9:0] load_val(input logic [9:0] r, input logic [9:0] cur);
`ifdef PWM_SOFT_START_EN
    int d;
    d = int'(r) - int'(cur);
    if (d > RAMP)       return cur + 10'(RAMP);
    else if (d < -RAMP) return cur - 10'(RAMP);
    else                return r;
`else
    if (cur == r) return cur;
    else          return r;
`endif
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic e, input logic [9:0] r, input int div);
    mstate_t n;
    n = s;
    if (!s.run) begin
      n = '0;
      if (e) begin
        n.run  = 1'b1;
        n.duty = load_val(r, 10'd0);
      end
    end else if (!e) begin
      n = '0;
    end else begin
      n.pwm = ((s.pos / 32'(div)) < 32'(s.duty));
      if (s.pos + 32'd1 == 32'(1023 * div)) begin
        n.pos  = 32'd0;
        n.duty = load_val(r, s.duty);
      end else begin
        n.pos  = s.pos + 32'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m1 <= '0;
      m4 <= '0;
    end else begin
      m1 <= step(m1, en, ref_v, 1);
      m4 <= step(m4, en, ref_v, 4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pwm_of(input int w);
    return (w == 1) ? if1.pwm_out : if4.pwm_out;
  endfunction

  function automatic logic ps_of(input int w);
    return (w == 1) ? if1.period_start : if4.period_start;
  endfunction

  task automatic tick();
    @(negedge clk);
    chk("pwm_div1",  32'(if1.pwm_out),      32'(m1.pwm));
    chk("ps_div1",   32'(if1.period_start), 32'(m1.run && (m1.pos == 32'd0)));
    chk("duty_div1", 32'(if1.duty_active),  32'(m1.duty));
    chk("pwm_div4",  32'(if4.pwm_out),      32'(m4.pwm));
    chk("ps_div4",   32'(if4.period_start), 32'(m4.run && (m4.pos == 32'd0)));
    chk("duty_div4", 32'(if4.duty_active),  32'(m4.duty));
  endtask

  // Called on a period_start clock; counts through the next one inclusive.
  task automatic measure(input int w, output int len, output int high);
    len  = 0;
    high = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      len++;
      if (pwm_of(w)) high++;
      if (ps_of(w)) break;
    end
  endtask

  task automatic sync(input int w);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (ps_of(w)) begin
        found = 1'b1;
        break;
      end
    end
    chk("sync_period_start", 32'(found), 32'd1);
  endtask

  initial begin
    int len;
    int high;
    int h2;
    repeat (3) tick();
    chk("reset_pwm",  32'(if1.pwm_out),      32'd0);
    chk("reset_ps",   32'(if1.period_start), 32'd0);
    chk("reset_duty", 32'(if1.duty_active),  32'd0);
    #2 reset_n = 1'b1;
    repeat (50) tick();
    chk("idle_pwm",  32'(if1.pwm_out),     32'd0);
    chk("idle_duty", 32'(if4.duty_active), 32'd0);

`ifndef PWM_SOFT_START_EN
    ref_v = 10'h200;
    en    = 1'b1;
    tick();
    chk("start_ps",   32'(if1.period_start), 32'd1);
    chk("start_duty", 32'(if1.duty_active),  32'h200);
    measure(1, len, high);
    chk("len_200",  32'(len),  32'd1023);
    chk("high_200", 32'(high), 32'd512);

    ref_v = 10'h000;
    measure(1, len, high);
    measure(1, len, high);
    chk("high_000", 32'(high), 32'd0);

    ref_v = 10'h3FF;
    measure(1, len, high);
    for (int k = 0; k < 3; k++) begin
      measure(1, len, high);
      chk("high_3ff", 32'(high), 32'd1023);
    end

    ref_v = 10'h066;
    measure(1, len, high);
    high = 0;
    repeat (50) begin
      tick();
      if (if1.pwm_out) high++;
    end
    ref_v = 10'h333;
    chk("mid_duty_held", 32'(if1.duty_active), 32'h066);
    measure(1, len, h2);
    chk("len_066",  32'(len + 50),  32'd1023);
    chk("high_066", 32'(high + h2), 32'd102);
    chk("duty_switch", 32'(if1.duty_active), 32'h333);
    measure(1, len, high);
    chk("high_333", 32'(high), 32'd819);

    ref_v = 10'h19A;
    sync(4);
    measure(4, len, high);
    chk("len_div4",  32'(len),  32'd4092);
    chk("high_div4", 32'(high), 32'd1640);
    repeat (100) tick();
    chk("div4_mid_pulse", 32'(if4.pwm_out), 32'd1);
    en = 1'b0;
    tick();
    chk("drop_pwm4", 32'(if4.pwm_out), 32'd0);
    chk("drop_pwm1", 32'(if1.pwm_out), 32'd0);
    repeat (5) tick();
    en = 1'b1;
    tick();
    chk("restart_ps4", 32'(if4.period_start), 32'd1);
    chk("restart_ps1", 32'(if1.period_start), 32'd1);
`else
    ref_v = 10'h200;
    en    = 1'b1;
    tick();
    chk("ramp_first", 32'(if1.duty_active), 32'd16);
    for (int k = 2; k <= 32; k++) begin
      sync(1);
      chk("ramp_step", 32'(if1.duty_active), 32'(16 * k));
    end
    ref_v = 10'h1F8;
    sync(1);
    chk("ramp_direct", 32'(if1.duty_active), 32'h1F8);
`endif

    for (int i = 0; i < 15000; i++) begin
      if (i == 6800) begin
        en    = 1'b1;
        ref_v = 10'h3FF;
      end else if (i < 6800 || i > 7000) begin
        if ($urandom_range(0, 199) == 0) begin
          case ($urandom_range(0, 3))
            0:       ref_v = 10'h000;
            1:       ref_v = 10'h3FF;
            default: ref_v = 10'($urandom);
          endcase
        end
        if (en && $urandom_range(0, 2999) == 0)      en = 1'b0;
        else if (!en && $urandom_range(0, 9) == 0)   en = 1'b1;
      end
      if (i == 7000) begin
        chk("pre_reset_running", 32'(if1.duty_active != 10'd0), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pwm1",  32'(if1.pwm_out),      32'd0);
        chk("async_ps1",   32'(if1.period_start), 32'd0);
        chk("async_duty1", 32'(if1.duty_active),  32'd0);
        chk("async_duty4", 32'(if4.duty_active),  32'd0);
        tick();
        #2 reset_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
